// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param
//   Behavioural model of a one-read/write plus one-read-only SRAM macro. It
//   has byte-lane write masking, a read latency of 1 or 2 cycles and
//   read-valid strobes. An optional zero-fill sweep runs after reset.
//   Port 0 carries the effect pipeline's writes into the delay/echo
//   buffers. Port 1 is the playback tap.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   csb0, web0        port 0 chip select / write enable (both active low)
//   wmask0            per-lane write enable, bit i covers din0[i*LW +: LW]
//   addr0, din0       port 0 address / write data
//   dout0, dvalid0    port 0 read data and its one-cycle strobe
//   csb1, addr1       port 1 chip select (active low) / address
//   dout1, dvalid1    port 1 read data and its one-cycle strobe
//   busy              clear sweep running; every request is ignored
module sram_1rw1r_param #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 14,
   parameter int WMASK_WIDTH    = 2,
   parameter int READ_LATENCY   = 1,
   parameter int WRITE_FIRST    = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   csb0,
   input  logic                   web0,
   input  logic [WMASK_WIDTH-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0]  din0,
   output logic [DATA_WIDTH-1:0]  dout0,
   output logic                   dvalid0,
   input  logic                   csb1,
   input  logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  dout1,
   output logic                   dvalid1,
   output logic                   busy
);
   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int LW        = DATA_WIDTH / WMASK_WIDTH;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   cnt;
   logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

   logic                    wr0, rd0, rd1;
   logic [DATA_WIDTH-1:0]   old0, wr_word, rdata1;

   // first read stage: one data/valid register per port
   logic [DATA_WIDTH-1:0]   s1_data0, s1_data1;
   logic                    s1_vld0, s1_vld1;

   assign busy = (state == CLEAR);
   assign wr0  = ~busy & ~csb0 & ~web0;
   assign rd0  = ~busy & ~csb0 &  web0;
   assign rd1  = ~busy & ~csb1;
   assign old0 = mem[addr0];

   // Merged write word: masked lanes come from din0 and the rest keep the
   // old contents. This lets one full-word write do a partial update.
   for (genvar i = 0; i < WMASK_WIDTH; i++) begin : g_lane
      assign wr_word[i*LW +: LW] = wmask0[i] ? din0[i*LW +: LW] : old0[i*LW +: LW];
   end

   // Collision: in write-first mode port 1 takes the word being written.
   // Otherwise it gets the array's pre-edge contents.
   assign rdata1 = (WRITE_FIRST != 0 && wr0 && addr0 == addr1) ? wr_word : mem[addr1];

   // Sweep FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         cnt   <= '0;
      end else if (state == CLEAR) begin
         cnt <= cnt + 1'b1;
         if (&cnt) state <= READY;   // this cycle writes the last word
      end
   end

   // Array. rst only blocks writes. It never alters the contents directly,
   // so the contents survive when the sweep is disabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (busy)     mem[cnt]   <= '0;
         else if (wr0) mem[addr0] <= wr_word;
      end
   end

   // Read stage 1. Data registers load only on a read, so idle ports hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld0  <= 1'b0;
         s1_vld1  <= 1'b0;
         s1_data0 <= '0;
         s1_data1 <= '0;
      end else begin
         s1_vld0 <= rd0;
         s1_vld1 <= rd1;
         if (rd0) s1_data0 <= old0;
         if (rd1) s1_data1 <= rdata1;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      // Extra output register. Reset flushes anything still in stage 1.
      always_ff @(posedge clk) begin
         if (rst) begin
            dvalid0 <= 1'b0;
            dvalid1 <= 1'b0;
            dout0   <= '0;
            dout1   <= '0;
         end else begin
            dvalid0 <= s1_vld0;
            dvalid1 <= s1_vld1;
            if (s1_vld0) dout0 <= s1_data0;
            if (s1_vld1) dout1 <= s1_data1;
         end
      end
   end else begin : g_lat1
      assign dout0   = s1_data0;
      assign dout1   = s1_data1;
      assign dvalid0 = s1_vld0;
      assign dvalid1 = s1_vld1;
   end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param. Two instances share one stimulus stream:
//   a: latency 1, write-first
//   b: latency 2, read-first (old data)
// Both use a 16-word array with the clear sweep enabled. Each read pushes
// its hand-computed value into a per-port queue. A negedge monitor pops
// and compares on every dvalid. Between strobes it checks that dout holds.
module tb_sram_1rw1r_param;
   logic        clk = 1'b0;
   logic        rst;
   logic        csb0, web0, csb1;
   logic [1:0]  wmask0;
   logic [3:0]  addr0, addr1;
   logic [15:0] din0;
   logic [15:0] a_dout0, a_dout1, b_dout0, b_dout1;
   logic        a_dvalid0, a_dvalid1, b_dvalid0, b_dvalid1, a_busy, b_busy;

   int tests = 0;
   int fails = 0;

   // queues: 0 = a port0, 1 = a port1, 2 = b port0, 3 = b port1
   logic [15:0] exq [4][$];
   logic [15:0] last [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
   string       nm [4] = '{"a_p0", "a_p1", "b_p0", "b_p1"};
   logic        rst_q = 1'b0;

   always #5 clk = ~clk;

   sram_1rw1r_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WMASK_WIDTH(2),
      .READ_LATENCY(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_a (
      .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
      .addr0(addr0), .din0(din0), .dout0(a_dout0), .dvalid0(a_dvalid0),
      .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dvalid1(a_dvalid1),
      .busy(a_busy));

   sram_1rw1r_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WMASK_WIDTH(2),
      .READ_LATENCY(2), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_b (
      .clk(clk), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
      .addr0(addr0), .din0(din0), .dout0(b_dout0), .dvalid0(b_dvalid0),
      .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dvalid1(b_dvalid1),
      .busy(b_busy));

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // monitor
   always @(posedge clk) rst_q <= rst;

   always @(negedge clk) begin
      logic [3:0]  dv;
      logic [15:0] dq [4];
      logic [15:0] e;
      dv = {b_dvalid1, b_dvalid0, a_dvalid1, a_dvalid0};
      dq[0] = a_dout0; dq[1] = a_dout1; dq[2] = b_dout0; dq[3] = b_dout1;
      for (int k = 0; k < 4; k++) begin
         if (rst_q) begin
            chk({nm[k], "_rst_dout"}, dq[k], 16'h0);
            chk({nm[k], "_rst_dvalid"}, 16'(dv[k]), 16'h0);
            last[k] = 16'h0;
         end else if (dv[k]) begin
            if (exq[k].size() == 0) begin
               tests++;
               fails++;
               $display("FAIL %s_unexpected_dvalid actual=1 expected=0 t=%0t", nm[k], $time);
            end else begin
               e = exq[k].pop_front();
               chk({nm[k], "_data"}, dq[k], e);
               last[k] = e;
            end
         end else begin
            chk({nm[k], "_hold"}, dq[k], last[k]);
         end
      end
   end

   // stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      csb0 = 1'b1; web0 = 1'b1; wmask0 = 2'b00; addr0 = '0; din0 = '0;
      csb1 = 1'b1; addr1 = '0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
      csb0 = 1'b0; web0 = 1'b0; wmask0 = m; addr0 = a; din0 = d;
      tick();
      idle();
   endtask

   task automatic rd0(input logic [3:0] a, input logic [15:0] e);
      csb0 = 1'b0; web0 = 1'b1; addr0 = a;
      exq[0].push_back(e);
      exq[2].push_back(e);
      tick();
      idle();
   endtask

   task automatic rd1(input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
      csb1 = 1'b0; addr1 = a;
      exq[1].push_back(ea);
      exq[3].push_back(eb);
      tick();
      idle();
   endtask

   // Count cycles with busy high, bounded so a stuck sweep cannot hang the run.
   task automatic wait_busy(input string name);
      int na = 0, nb = 0, n = 0;
      while ((a_busy || b_busy) && n < 100) begin
         na += int'(a_busy);
         nb += int'(b_busy);
         n++;
         tick();
      end
      chk({name, "_a_busy_cycles"}, 16'(na), 16'd16);
      chk({name, "_b_busy_cycles"}, 16'(nb), 16'd16);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      wait_busy("init");

      // clear sweep wipes an earlier write
      wr(4'd3, 16'hBEEF, 2'b11);
      rd1(4'd3, 16'hBEEF, 16'hBEEF);
      repeat (3) tick();
      pulse_rst();
      wait_busy("clear");
      rd1(4'd3, 16'h0000, 16'h0000);

      // masked write
      wr(4'd5, 16'h1234, 2'b11);
      wr(4'd5, 16'hABCD, 2'b01);
      rd0(4'd5, 16'h12CD);

      // collision: a is write-first, b returns old data
      wr(4'd7, 16'h00FF, 2'b11);
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 2'b10; addr0 = 4'd7; din0 = 16'h5555;
      csb1 = 1'b0; addr1 = 4'd7;
      exq[1].push_back(16'h55FF);
      exq[3].push_back(16'h00FF);
      tick();
      idle();
      rd1(4'd7, 16'h55FF, 16'h55FF);

      // back-to-back reads and latency
      repeat (3) tick();
      wr(4'd0, 16'h000A, 2'b11);
      wr(4'd1, 16'h000B, 2'b11);
      wr(4'd2, 16'h000C, 2'b11);
      csb1 = 1'b0; addr1 = 4'd0;
      exq[1].push_back(16'h000A); exq[3].push_back(16'h000A);
      tick();
      chk("lat_a_first_dvalid", 16'(a_dvalid1), 16'd1);
      chk("lat_b_first_dvalid", 16'(b_dvalid1), 16'd0);
      addr1 = 4'd1;
      exq[1].push_back(16'h000B); exq[3].push_back(16'h000B);
      tick();
      chk("lat_b_dvalid_1", 16'(b_dvalid1), 16'd1);
      chk("lat_b_dout_1", b_dout1, 16'h000A);
      chk("lat_a_dout_2", a_dout1, 16'h000B);
      addr1 = 4'd2;
      exq[1].push_back(16'h000C); exq[3].push_back(16'h000C);
      tick();
      chk("lat_b_dvalid_2", 16'(b_dvalid1), 16'd1);
      chk("lat_b_dout_2", b_dout1, 16'h000B);
      idle();
      tick();
      chk("lat_b_dvalid_3", 16'(b_dvalid1), 16'd1);
      chk("lat_b_dout_3", b_dout1, 16'h000C);
      chk("lat_a_idle_dvalid", 16'(a_dvalid1), 16'd0);
      tick();
      chk("lat_b_idle_dvalid", 16'(b_dvalid1), 16'd0);

      // hold while idle, and wmask0 = 0 is a no-op
      wr(4'd9, 16'h1111, 2'b11);
      rd1(4'd9, 16'h1111, 16'h1111);
      repeat (10) tick();
      wr(4'd9, 16'h2222, 2'b00);
      rd0(4'd9, 16'h1111);
      repeat (3) tick();

      // reset mid-sweep. Reads issued while busy must never produce dvalid.
      pulse_rst();
      for (int i = 0; i < 9; i++) begin
         csb0 = 1'b0; web0 = 1'b1; addr0 = 4'(i);
         csb1 = 1'b0; addr1 = 4'(i);
         tick();
      end
      idle();
      chk("midsweep_still_busy", 16'(a_busy), 16'd1);
      pulse_rst();
      wait_busy("midsweep");

      // reset with a latency-2 read in flight: only a responds
      csb1 = 1'b0; addr1 = 4'd4;
      exq[1].push_back(16'h0000);
      tick();
      idle();
      pulse_rst();
      wait_busy("inflight");
      repeat (4) tick();

      for (int k = 0; k < 4; k++) chk({nm[k], "_drain"}, 16'(exq[k].size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
